commit_buffer: RTL and testbench
================================

Name: commit_buffer

Overview:
- In-order completion/retire buffer that consumes the single `complete` Result stream produced by the result queue.
- The dispatch stage allocates commit_ids in program order, and results arrive out of order keyed by commit_id.
- The block retires entries strictly in allocation order to the commit/writeback stage over a valid/ready handshake.
- It also drives the result queue's `stall` input when it cannot accept a completion.

Parameters:
- BUF_SIZE, 64, number of slots; power of two, 2..128; commit_id = slot index.
- ID_W, 8, width of commit_id (w8); only the low log2(BUF_SIZE) bits are significant.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flash  in  1  pipeline flush; synchronous, same effect as reset on state
- alloc_req  in  1  dispatch requests one commit_id this cycle
- alloc_ok  out  1  combinational; high when not full; allocation happens iff alloc_req & alloc_ok
- alloc_id  out  ID_W  combinational; commit_id granted (= tail index)
- complete  in  50  Result {en, commit_id[7:0], kind[8:0], content[31:0]}; en qualifies
- complete_stall  out  1  registered; tells the result queue to hold its output
- commit_valid  out  1  registered; head entry is done
- commit_ready  in  1  consumer accepts; retire occurs iff commit_valid & commit_ready
- commit_id  out  ID_W  registered; head index
- commit_kind  out  9  registered; kind field of head result
- commit_content  out  32  registered; content field of head result
- empty  out  1  combinational; count == 0
- count  out  8  registered; number of allocated, unretired slots

Behaviour:

Storage and pointers:
- head, tail: log2(BUF_SIZE)-bit pointers that wrap modulo BUF_SIZE.
- count: 0..BUF_SIZE.
- Per-slot registers: alloc bit and done bit.
- Per-slot {kind, content} payload, 41 bits, held in a RAM with a synchronous write port.

Allocation:
- full = (count == BUF_SIZE).
- On an alloc handshake: set alloc[tail], clear done[tail], tail++.
- Allocation is refused when full even if a retire happens in the same cycle; no same-cycle slot reuse.

Completion:
- Accepted when complete.en & ~complete_stall & alloc[id] & ~done[id], where id = the low bits of complete.commit_id.
- On accept: write the payload, set done[id].
- A completion to an unallocated or already-done slot is dropped with no state change. The bench checks this via an assertion counter; it is not a port.

Commit / retire:
- The commit outputs are registered from head state. commit_valid rises one cycle after the cycle in which done[head] becomes set.
- Minimum complete-to-commit latency is 1 cycle when the completing slot is head.
- On a retire handshake: clear alloc[head] and done[head], head++. The next head's outputs are valid the following cycle if it is already done, giving back-to-back retire at 1/cycle.
- commit_* outputs hold stable while commit_valid & ~commit_ready.

Counter and stall:
- count' = count + alloc_hs - retire_hs.
- complete_stall asserts when the payload RAM write port is unavailable. In this design that is only the cycle after reset/flash, when the buffer is initialising; it is otherwise 0.

Simultaneous events:
- alloc, complete and retire may all occur in one cycle.
- A completion targeting the slot being retired that same cycle cannot occur, because that slot is already done, and is dropped.
- A completion targeting the slot being allocated that same cycle is dropped, because alloc is not yet set.

Reset / flash:
- head = tail = count = 0; all alloc/done bits cleared.
- commit_valid = 0, commit_id = 0, commit_kind = 0, commit_content = 0, complete_stall = 1 for exactly one cycle, then 0.
- While flash is high, the complete input is ignored and no alloc or retire occurs, regardless of the handshakes.
- reset and flash asserted mid-stream discard all in-flight entries; payload RAM contents are don't-care.

Wrap-around:
- The ids issued after id BUF_SIZE-1 restart at 0.
- Ordering is defined solely by head-to-tail distance.

Test Plan:
- Reset, then 3 allocs: alloc_id returns 0, 1, 2. Completions arrive in order 2, 0, 1 with content 0xC, 0xA, 0xB; commit_ready=1. Commits appear in order id0/0xA, id1/0xB, id2/0xC. The first commit is 1 cycle after id0 completes; the next two are back-to-back.
- Fill: 64 allocs, then alloc_ok=0 and count=64. Complete and retire id0 while alloc_req=1 in the same cycle: the alloc is refused that cycle and granted next cycle with alloc_id=0 (wrap).
- Backpressure: head done with commit_ready=0 for 5 cycles. commit_valid stays high and commit_id/kind/content stay constant; on ready=1, exactly one retire occurs.
- Drop cases: complete with en=1 to unallocated id 10, then a duplicate complete to done id 1. There is no change to done bits or commit output and count is unchanged.
- Flush: 20 entries allocated, 7 done. Assert flash for 1 cycle. Next cycle: count=0, commit_valid=0, empty=1, complete_stall=1 for one cycle. A completion presented during flash is ignored. The next alloc returns id 0.
- Concurrency: in a single cycle, alloc (tail=5), complete id 3, and retire id 2 all fire. count is unchanged, tail=6, done[3]=1, head=3; id3 commits the following cycle.

Source files
------------

// File: rtl/commit_buffer.sv
// In-order retire buffer: allocates commit_ids in program order, absorbs
// out-of-order completions keyed by commit_id, and retires from the head.
module commit_buffer #(
    parameter int BUF_SIZE = 64,
    parameter int ID_W     = 8
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flash,
    input  logic            alloc_req,
    output logic            alloc_ok,
    output logic [ID_W-1:0] alloc_id,
    input  logic [49:0]     complete,
    output logic            complete_stall,
    output logic            commit_valid,
    input  logic            commit_ready,
    output logic [ID_W-1:0] commit_id,
    output logic [8:0]      commit_kind,
    output logic [31:0]     commit_content,
    output logic            empty,
    output logic [7:0]      count
);

    localparam int PTR_W = $clog2(BUF_SIZE);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_SIZE);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [PTR_W-1:0]    head_q, head_d;
    logic [PTR_W-1:0]    tail_q, tail_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [BUF_SIZE-1:0] alloc_q, alloc_d;
    logic [BUF_SIZE-1:0] done_q, done_d;
    logic                stall_q;
    logic                commit_valid_q, commit_valid_d;
    logic [ID_W-1:0]     commit_id_q, commit_id_d;
    logic [40:0]         payload_q, payload_d;
    logic [40:0]         ram_q [BUF_SIZE];

    logic                cpl_en_s;
    logic [PTR_W-1:0]    cpl_idx_s;
    logic [40:0]         cpl_payload_s;
    logic                cpl_id_unused_s;
    logic                cpl_acc_s;
    logic                alloc_hs_s;
    logic                retire_hs_s;

    assign cpl_en_s        = complete[49];
    assign cpl_idx_s       = complete[41 +: PTR_W];
    assign cpl_payload_s   = complete[40:0];
    assign cpl_id_unused_s = ^complete[48:41+PTR_W];

    assign alloc_ok    = (count_q != FULL_CNT);
    assign alloc_id    = ID_W'(tail_q);
    assign empty       = (count_q == CNT_ZERO);
    assign count       = 8'(count_q);

    // A slot allocated this same cycle is not yet marked, so its completion is dropped
    assign alloc_hs_s  = alloc_req & alloc_ok & ~flash;
    assign retire_hs_s = commit_valid_q & commit_ready & ~flash;
    assign cpl_acc_s   = cpl_en_s & ~stall_q & ~flash
                       & alloc_q[cpl_idx_s] & ~done_q[cpl_idx_s];

    assign complete_stall = stall_q;
    assign commit_valid   = commit_valid_q;
    assign commit_id      = commit_id_q;
    assign commit_kind    = payload_q[40:32];
    assign commit_content = payload_q[31:0];

    // Next-state for pointers, slot bits and the head-derived commit outputs
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        alloc_d = alloc_q;
        done_d  = done_q;
        if (retire_hs_s) begin
            alloc_d[head_q] = 1'b0;
            done_d[head_q]  = 1'b0;
            head_d          = head_q + PTR_ONE;
        end else begin
            head_d = head_q;
        end
        if (alloc_hs_s) begin
            alloc_d[tail_q] = 1'b1;
            done_d[tail_q]  = 1'b0;
            tail_d          = tail_q + PTR_ONE;
        end else begin
            tail_d = tail_q;
        end
        if (cpl_acc_s) begin
            done_d[cpl_idx_s] = 1'b1;
        end else begin
            done_d[cpl_idx_s] = done_d[cpl_idx_s];
        end
        count_d        = count_q + CNT_W'(alloc_hs_s) - CNT_W'(retire_hs_s);
        commit_valid_d = done_d[head_d];
        commit_id_d    = ID_W'(head_d);
        // Bypass the RAM when the head's payload is being written this same edge
        if (commit_valid_d) begin
            if (cpl_acc_s && (cpl_idx_s == head_d)) begin
                payload_d = cpl_payload_s;
            end else begin
                payload_d = ram_q[head_d];
            end
        end else begin
            payload_d = payload_q;
        end
    end

    // State registers; reset and flash both return the buffer to empty
    always_ff @(posedge clock) begin
        if (reset || flash) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            alloc_q        <= '0;
            done_q         <= '0;
            stall_q        <= 1'b1;
            commit_valid_q <= 1'b0;
            commit_id_q    <= '0;
            payload_q      <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            alloc_q        <= alloc_d;
            done_q         <= done_d;
            stall_q        <= 1'b0;
            commit_valid_q <= commit_valid_d;
            commit_id_q    <= commit_id_d;
            payload_q      <= payload_d;
        end
    end

    // Payload RAM write port; contents are don't-care after reset
    always_ff @(posedge clock) begin
        if (cpl_acc_s) begin
            ram_q[cpl_idx_s] <= cpl_payload_s;
        end
    end

endmodule

// File: tb/tb_commit_buffer.sv
// Bench for commit_buffer: directed scenarios followed by random traffic,
// all checked against an in-order queue model of the buffer.
module tb_commit_buffer;

    localparam int N = 64;

    logic        clock = 1'b0;
    logic        reset;
    logic        flash;
    logic        alloc_req;
    logic        alloc_ok;
    logic [7:0]  alloc_id;
    logic [49:0] complete;
    logic        complete_stall;
    logic        commit_valid;
    logic        commit_ready;
    logic [7:0]  commit_id;
    logic [8:0]  commit_kind;
    logic [31:0] commit_content;
    logic        empty;
    logic [7:0]  count;

    commit_buffer #(.BUF_SIZE(N), .ID_W(8)) dut (
        .clock          (clock),
        .reset          (reset),
        .flash          (flash),
        .alloc_req      (alloc_req),
        .alloc_ok       (alloc_ok),
        .alloc_id       (alloc_id),
        .complete       (complete),
        .complete_stall (complete_stall),
        .commit_valid   (commit_valid),
        .commit_ready   (commit_ready),
        .commit_id      (commit_id),
        .commit_kind    (commit_kind),
        .commit_content (commit_content),
        .empty          (empty),
        .count          (count)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          id;
        bit          done;
        logic [8:0]  kind;
        logic [31:0] content;
    } ent_t;

    ent_t mq[$];
    int   next_id;
    bit   m_stall;
    int   checks;
    int   failures;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_valid();
        return (mq.size() > 0) && mq[0].done;
    endfunction

    function automatic int m_head();
        return (mq.size() > 0) ? mq[0].id : next_id;
    endfunction

    task automatic check_regs();
        chk("commit_valid", 64'(commit_valid), 64'(m_valid()));
        chk("commit_id", 64'(commit_id), 64'(m_head()));
        chk("count", 64'(count), 64'(mq.size()));
        chk("complete_stall", 64'(complete_stall), 64'(m_stall));
        if (m_valid()) begin
            chk("commit_kind", 64'(commit_kind), 64'(mq[0].kind));
            chk("commit_content", 64'(commit_content), 64'(mq[0].content));
        end
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registers
    task automatic step(input bit a_req, input bit c_en, input int c_id,
                        input logic [8:0] c_kind, input logic [31:0] c_cont,
                        input bit rdy, input bit fl);
        bit full;
        bit do_alloc;
        bit do_retire;
        int idx;
        alloc_req    = a_req;
        complete     = {c_en, 8'(c_id), c_kind, c_cont};
        commit_ready = rdy;
        flash        = fl;
        #1;
        full = (mq.size() == N);
        chk("alloc_ok", 64'(alloc_ok), 64'(!full));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("alloc_id", 64'(alloc_id), 64'(next_id));
        do_alloc  = a_req && !full && !fl;
        do_retire = m_valid() && rdy && !fl;
        if (c_en && !m_stall && !fl) begin
            idx = -1;
            foreach (mq[i]) begin
                if (mq[i].id == (c_id % N) && !mq[i].done) idx = i;
            end
            if (idx >= 0) begin
                mq[idx].done    = 1'b1;
                mq[idx].kind    = c_kind;
                mq[idx].content = c_cont;
            end
        end
        if (do_retire) void'(mq.pop_front());
        if (do_alloc) begin
            mq.push_back('{next_id, 1'b0, 9'h0, 32'h0});
            next_id = (next_id + 1) % N;
        end
        m_stall = fl;
        if (fl) begin
            mq.delete();
            next_id = 0;
        end
        @(posedge clock);
        #1;
        check_regs();
    endtask

    task automatic idle(input bit rdy);
        step(1'b0, 1'b0, 0, 9'h0, 32'h0, rdy, 1'b0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        flash        = 1'b0;
        alloc_req    = 1'b0;
        complete     = '0;
        commit_ready = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        mq.delete();
        next_id = 0;
        m_stall = 1'b1;
        check_regs();
        chk("rst_kind", 64'(commit_kind), 64'h0);
        chk("rst_content", 64'(commit_content), 64'h0);
        chk("rst_empty", 64'(empty), 64'h1);
    endtask

    initial begin
        int cid;
        bit a;
        bit c;
        bit r;
        bit f;
        checks   = 0;
        failures = 0;

        // In-order retire of out-of-order completions
        do_reset();
        repeat (3) step(1'b1, 1'b0, 0, 9'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 2, 9'h1, 32'hC, 1'b1, 1'b0);
        chk("t1_wait_head", 64'(commit_valid), 64'h0);
        step(1'b0, 1'b1, 0, 9'h1, 32'hA, 1'b1, 1'b0);
        chk("t1_c0_id", 64'(commit_id), 64'h0);
        chk("t1_c0_data", 64'(commit_content), 64'hA);
        step(1'b0, 1'b1, 1, 9'h1, 32'hB, 1'b1, 1'b0);
        chk("t1_c1_id", 64'(commit_id), 64'h1);
        chk("t1_c1_data", 64'(commit_content), 64'hB);
        idle(1'b1);
        chk("t1_c2_id", 64'(commit_id), 64'h2);
        chk("t1_c2_data", 64'(commit_content), 64'hC);
        idle(1'b1);
        chk("t1_drained", 64'(count), 64'h0);

        // Fill to capacity; retire while full refuses the same-cycle alloc
        do_reset();
        repeat (N) step(1'b1, 1'b0, 0, 9'h0, 32'h0, 1'b0, 1'b0);
        chk("t2_full_ok", 64'(alloc_ok), 64'h0);
        chk("t2_full_cnt", 64'(count), 64'd64);
        step(1'b1, 1'b1, 0, 9'h2, 32'hD0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 0, 9'h0, 32'h0, 1'b1, 1'b0);
        chk("t2_refused", 64'(count), 64'd63);
        chk("t2_wrap_id", 64'(alloc_id), 64'h0);
        step(1'b1, 1'b0, 0, 9'h0, 32'h0, 1'b0, 1'b0);
        chk("t2_granted", 64'(count), 64'd64);

        // Backpressure on the head
        step(1'b0, 1'b1, 1, 9'h3, 32'hBEEF, 1'b0, 1'b0);
        repeat (5) idle(1'b0);
        chk("t3_hold_valid", 64'(commit_valid), 64'h1);
        chk("t3_hold_id", 64'(commit_id), 64'h1);
        chk("t3_hold_data", 64'(commit_content), 64'hBEEF);
        idle(1'b1);
        chk("t3_one_retire", 64'(count), 64'd63);

        // Dropped completions: unallocated slot and duplicate
        do_reset();
        repeat (3) step(1'b1, 1'b0, 0, 9'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1, 9'h4, 32'h11, 1'b0, 1'b0);
        step(1'b0, 1'b1, 10, 9'h5, 32'h99, 1'b0, 1'b0);
        chk("t4_cnt", 64'(count), 64'd3);
        step(1'b0, 1'b1, 1, 9'h6, 32'h22, 1'b0, 1'b0);
        step(1'b0, 1'b1, 0, 9'h7, 32'h10, 1'b1, 1'b0);
        idle(1'b1);
        chk("t4_dup_kept", 64'(commit_content), 64'h11);

        // Flush mid-stream
        do_reset();
        repeat (20) step(1'b1, 1'b0, 0, 9'h0, 32'h0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, i, 9'h8, 32'h100 + 32'(i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 7, 9'h9, 32'h777, 1'b1, 1'b1);
        chk("t5_cnt", 64'(count), 64'h0);
        chk("t5_valid", 64'(commit_valid), 64'h0);
        chk("t5_stall", 64'(complete_stall), 64'h1);
        chk("t5_empty", 64'(empty), 64'h1);
        chk("t5_alloc_id", 64'(alloc_id), 64'h0);
        step(1'b1, 1'b1, 0, 9'h9, 32'h55, 1'b0, 1'b0);
        chk("t5_unstall", 64'(complete_stall), 64'h0);
        step(1'b0, 1'b1, 0, 9'h9, 32'h66, 1'b0, 1'b0);

        // Alloc, complete and retire in one cycle
        do_reset();
        repeat (5) step(1'b1, 1'b0, 0, 9'h0, 32'h0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 0, 9'h1, 32'hA0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1, 9'h1, 32'hA1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 2, 9'h1, 32'hA2, 1'b1, 1'b0);
        step(1'b1, 1'b1, 3, 9'h1A, 32'hA3, 1'b1, 1'b0);
        chk("t6_cnt", 64'(count), 64'd3);
        chk("t6_tail", 64'(alloc_id), 64'd6);
        chk("t6_head", 64'(commit_id), 64'd3);
        chk("t6_valid", 64'(commit_valid), 64'h1);
        chk("t6_data", 64'(commit_content), 64'hA3);

        // Random traffic
        do_reset();
        for (int n = 0; n < 4000; n++) begin
            a = ($urandom_range(0, 99) < ((n % 1000) < 500 ? 80 : 35));
            c = ($urandom_range(0, 99) < 75);
            r = ($urandom_range(0, 99) < 65);
            f = ($urandom_range(0, 255) == 0);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                cid = mq[$urandom_range(0, mq.size() - 1)].id;
            else
                cid = $urandom_range(0, 255);
            step(a, c, cid, 9'($urandom), $urandom, r, f);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
